// File: rtl/u_icache.sv
`default_nettype none
// ============================================================================
// Module   : u_icache
// Purpose  : Direct-mapped, read-only instruction cache in front of the fetch
//            stage. Combinational hit path; on a miss the whole line is
//            refilled word-by-word over a req/ack memory bus. flush_i
//            invalidates every line (fence.i).
// Options  : ICACHE_PERF_EN adds miss_count_o / refill_cycles_o counters.
// Revision : 1.0 - initial release
// ============================================================================
module u_icache #(
   parameter int LINES          = 64,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:2] address_i,
   output logic [31:0] read_data_o,
   output logic        busywait_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic [31:2] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0] miss_count_o,
   output logic [31:0] refill_cycles_o
`endif
);

   localparam int OFF    = $clog2(WORDS_PER_LINE);
   localparam int IDX    = $clog2(LINES);
   localparam int TAG_W  = 30 - OFF - IDX;
   localparam int LINE_W = TAG_W + IDX;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

   // Address fields of the fetch request
   logic [OFF-1:0]   addr_off;
   logic [IDX-1:0]   addr_idx;
   logic [TAG_W-1:0] addr_tag;

   assign addr_off = address_i[OFF+1:2];
   assign addr_idx = address_i[OFF+IDX+1:OFF+2];
   assign addr_tag = address_i[31:OFF+IDX+2];

   // Storage arrays (no reset needed: only reachable through a valid bit)
   logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0] tag_mem  [LINES];

   // Control state
   state_t            state_q, state_d;
   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINE_W-1:0] miss_line_q, miss_line_d;
   logic [OFF-1:0]    cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              flush_pending_q, flush_pending_d;

   logic              data_we;
   logic              tag_we;
   logic              last_word;
   logic              hit;
   logic [IDX-1:0]    miss_idx;
   logic [TAG_W-1:0]  miss_tag;

   assign miss_idx  = miss_line_q[IDX-1:0];
   assign miss_tag  = miss_line_q[LINE_W-1:IDX];
   assign last_word = (cnt_q == OFF'(WORDS_PER_LINE - 1));

   // A flush cycle always looks like a miss so the fetch stage never sees
   // data from a line that is being invalidated at this edge.
   assign hit = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag) &&
                (state_q == ST_IDLE) && !flush_i;

   assign busywait_o  = !hit;
   assign read_data_o = data_mem[{addr_idx, addr_off}];
   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = {miss_line_q, cnt_q};

   // Next-state logic for the lookup/refill controller
   always_comb begin
      state_d         = state_q;
      valid_d         = valid_q;
      miss_line_d     = miss_line_q;
      cnt_d           = cnt_q;
      mem_req_d       = mem_req_q;
      flush_pending_d = flush_pending_q;
      data_we         = 1'b0;
      tag_we          = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_i) begin
               valid_d = '0;
            end else if (!hit) begin
               state_d     = ST_REFILL;
               miss_line_d = {addr_tag, addr_idx};
               cnt_d       = '0;
               mem_req_d   = 1'b1;
            end
         end
         ST_REFILL: begin
            if (flush_i) begin
               flush_pending_d = 1'b1;
            end
            if (mem_ack_i) begin
               data_we = 1'b1;
               cnt_d   = cnt_q + OFF'(1);
               if (last_word) begin
                  tag_we          = 1'b1;
                  state_d         = ST_IDLE;
                  mem_req_d       = 1'b0;
                  flush_pending_d = 1'b0;
                  // A flush seen at any point of the refill wins over the
                  // newly fetched line.
                  if (flush_pending_q || flush_i) begin
                     valid_d = '0;
                  end else begin
                     valid_d[miss_idx] = 1'b1;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         valid_q         <= '0;
         miss_line_q     <= '0;
         cnt_q           <= '0;
         mem_req_q       <= 1'b0;
         flush_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         valid_q         <= valid_d;
         miss_line_q     <= miss_line_d;
         cnt_q           <= cnt_d;
         mem_req_q       <= mem_req_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   // Data and tag array writes during refill
   always_ff @(posedge clk_i) begin
      if (!rst_i && data_we) begin
         data_mem[{miss_idx, cnt_q}] <= mem_data_i;
      end
      if (!rst_i && tag_we) begin
         tag_mem[miss_idx] <= miss_tag;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] miss_count_q, miss_count_d;
   logic [31:0] refill_cycles_q, refill_cycles_d;

   // Saturating performance counters
   always_comb begin
      miss_count_d    = miss_count_q;
      refill_cycles_d = refill_cycles_q;
      if (state_q == ST_IDLE && state_d == ST_REFILL && miss_count_q != '1) begin
         miss_count_d = miss_count_q + 32'd1;
      end
      if (state_q == ST_REFILL && refill_cycles_q != '1) begin
         refill_cycles_d = refill_cycles_q + 32'd1;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         miss_count_q    <= '0;
         refill_cycles_q <= '0;
      end else begin
         miss_count_q    <= miss_count_d;
         refill_cycles_q <= refill_cycles_d;
      end
   end

   assign miss_count_o    = miss_count_q;
   assign refill_cycles_o = refill_cycles_q;
`endif

endmodule
`default_nettype wire

// File: doc/u_icache.md
# u_icache

Direct-mapped, read-only instruction cache sitting directly upstream of the instruction fetch stage. It answers word addresses from the fetch stage combinationally on a hit. On a miss it raises busywait and refills the whole line from the instruction memory bus through a word-by-word request/acknowledge handshake. A flush input invalidates the cache for `fence.i`.

## Interface
- `LINES`, 64, number of cache lines; power of two, at least 2.
- `WORDS_PER_LINE`, 4, 32-bit words per line; power of two, at least 2.
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `address_i` in [31:2]: word address from the fetch stage.
- `read_data_o` out [31:0]: instruction word at `address_i`; valid only when `busywait_o`=0.
- `busywait_o` out 1: fetch stage must hold; high on miss or while refilling.
- `flush_i` in 1: single-cycle pulse that invalidates all lines.
- `mem_req_o` out 1: refill word request.
- `mem_addr_o` out [31:2]: refill word address.
- `mem_ack_i` in 1: memory accepted the request; `mem_data_i` is valid in the same cycle.
- `mem_data_i` in [31:0]: refill word.

## Operation
- **Address split:**
  - OFF = log2(WORDS_PER_LINE) bits: `address_i[OFF+1:2]`.
  - IDX = log2(LINES) bits above the offset.
  - Tag is the remaining upper bits. With the defaults: offset [3:2], index [9:4], tag [31:10] (22 bits).
- **Storage:** data array LINES×WORDS_PER_LINE×32, tag array, and a valid bit per line.
- **hit** = valid[idx] && tag[idx]==tag(address_i) && state==IDLE.
- **busywait_o** = !hit, evaluated combinationally.
- **FSM states:**
  - IDLE: on miss and no flush → REFILL. Latch `miss_line` = {tag, idx}, clear the word counter, set `mem_req_o` next cycle.
  - REFILL: `mem_req_o`=1 and `mem_addr_o` = {miss_line, counter}.
    - Each `mem_ack_i`: write `mem_data_i` into data[idx][counter] and increment the counter.
    - On the ack of word WORDS_PER_LINE-1: write the tag, set valid unless a flush is pending, and go to IDLE.
- Refill always starts at word 0 and fetches words in ascending order. `mem_addr_o` only changes on the cycle after an ack.
- If `address_i` changes during REFILL (branch), the current refill still completes for `miss_line`. The new address is looked up in IDLE afterwards.
- **flush_i:**
  - In IDLE: all valid bits clear at the edge. Lookup that cycle is still forced to miss, but the FSM stays in IDLE that cycle.
  - In REFILL: sets `flush_pending`. The refill completes, all valid bits clear, the refilled line is left invalid, and `flush_pending` clears.
- **Reset:** state IDLE, all valid=0, `flush_pending`=0, counter=0.
  - Reset mid-refill abandons the refill with no line validated.
  - The outstanding memory request is dropped; a late `mem_ack_i` after reset is ignored.
- **Reset values:** `mem_req_o`=0, `mem_addr_o`=0, `busywait_o`=1 (all lines invalid), `read_data_o` don't-care.

## Timing
- Hit: zero latency; `read_data_o` and `busywait_o`=0 in the same cycle `address_i` is presented.
- Miss with a zero-wait memory (ack in the same cycle as request):
  - Cycle 0: miss detected.
  - Cycles 1..WORDS_PER_LINE: REFILL.
  - Cycle WORDS_PER_LINE+1: hit, `busywait_o`=0 (5 cycles with defaults).
- Each memory wait cycle adds one cycle to that total.
- `busywait_o` stays 1 during the cycle of the final ack; data becomes visible the following cycle.
- `mem_req_o` stays high continuously across all words of a refill.

## Configuration
- **`ICACHE_PERF_EN` defined:** adds two 32-bit saturating counters, both reset to 0 by `rst_i`.
  - `miss_count_o` out [31:0]: increments on each IDLE→REFILL transition.
  - `refill_cycles_o` out [31:0]: increments every cycle spent in REFILL.
- **`ICACHE_PERF_EN` undefined:** these ports and registers do not exist; all other behaviour is identical.

## Test plan
- **Reset cold miss:** after reset, present 0x100 (word address 0x40); memory returns data=addr×4 with zero wait.
  - `mem_addr_o` steps 0x40,0x41,0x42,0x43.
  - `busywait_o` falls in cycle 5 with `read_data_o`=0x100.
  - Address 0x41 then hits with 0x104 and zero latency.
- **Conflict eviction:** fetch word 0x40, then word 0x140 (same index, different tag).
  - Second access misses and refills.
  - Re-accessing 0x40 misses again.
- **Memory wait states:** ack delayed by 2 cycles per word.
  - Miss resolves in 13 cycles.
  - `mem_addr_o` is stable while `mem_req_o`=1 and no ack.
- **Branch mid-refill:** `address_i` changes from 0x40 to 0x200 after the second ack.
  - Line 0x40 completes and is valid.
  - A 0x200 refill starts on the next cycle.
- **Flush:** with 0x40 cached, pulse `flush_i` in IDLE; next access to 0x40 misses. Pulse `flush_i` during a refill; that line is still invalid afterwards.
- **Reset mid-refill:** assert `rst_i` after one ack.
  - `mem_req_o`=0 the next cycle.
  - A late ack is ignored.
  - A subsequent access misses.
  - With `ICACHE_PERF_EN`, the counters read 0.
